// File: rtl/axis_data_pkg.sv
// Shared definitions for the AXI-Stream test pattern generator and checker:
// lane geometry, pattern field widths, lane-word builder, checker state enum
// and the per-beat control word carried down the checker pipeline.
package axis_data_pkg;

  localparam int LANE_W     = 64;
  localparam int SEQ_W      = 32;
  localparam int BEAT_W     = 24;
  localparam int LANE_IDX_W = 8;
  localparam int CNT_W      = 32;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SKIP  = 2'd2
  } chk_state_e;

  // Per-beat control travelling alongside the data through the pipeline.
  typedef struct packed {
    logic             cmp;      // beat is compared against the pattern
    logic             close;    // beat ends a packet
    logic             len_err;  // closing packet had the wrong length
    logic             user;     // tuser seen on the closing beat
    logic             sop;      // first compared beat of a packet
    logic [SEQ_W-1:0] drop;     // packets missing before this one
  } pkt_ctl_t;

  // Expected 64-bit lane: {seq, beat index, lane index}.
  function automatic logic [LANE_W-1:0] lane_word(input logic [SEQ_W-1:0]      seq,
                                                  input logic [BEAT_W-1:0]     beat,
                                                  input logic [LANE_IDX_W-1:0] j);
    return {seq, beat, j};
  endfunction

  // Saturating add; counters pin at all ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/axis_data_chk_lane_cmp.sv
// One 64-bit lane of the checker: compares the registered beat lane against
// the expected pattern word and folds data and tkeep mismatches into a single
// registered flag, keeping the wide XOR/OR tree local to each lane.
module axis_data_chk_lane_cmp
  import axis_data_pkg::*;
#(
  parameter int LANE_IDX = 0
) (
  input  logic                  clk,
  input  logic [LANE_W-1:0]     data,
  input  logic [LANE_W/8-1:0]   keep,
  input  logic [SEQ_W-1:0]      exp_seq,
  input  logic [BEAT_W-1:0]     exp_beat,
  output logic                  mismatch
);

  localparam logic [LANE_IDX_W-1:0] J = LANE_IDX_W'(LANE_IDX);

  // Register lane mismatch: any differing bit or any cleared byte enable.
  always_ff @(posedge clk) begin
    mismatch <= (|(data ^ lane_word(exp_seq, exp_beat, J))) | ~(&keep);
  end

endmodule

// File: rtl/axis_data_chk.sv
// AXI-Stream test traffic checker. Locks onto the generator's sequence,
// checks every beat against the deterministic lane pattern, checks packet
// length and sequence continuity, and keeps saturating counters.
// Pipeline: accept/FSM -> stage 1 (beat + expected value registered)
//           -> stage 2 (per-lane compare registered) -> counters.
// Optional macro AXIS_DATA_CHK_BACKPRESSURE_EN: LFSR-driven tready.
module axis_data_chk
  import axis_data_pkg::*;
#(
  parameter int G_AXIS_DATA_WIDTH = 1024
) (
  input  logic                           axis_streaming_data_clk,
  input  logic                           axis_streaming_arst,
  input  logic                           axis_data_chk_enable,
  input  logic                           axis_data_chk_clear,
  input  logic [15:0]                    pkt_length,
  input  logic [G_AXIS_DATA_WIDTH-1:0]   axis_streaming_data_rx_tdata,
  input  logic                           axis_streaming_data_rx_tvalid,
  input  logic                           axis_streaming_data_rx_tuser,
  input  logic [G_AXIS_DATA_WIDTH/8-1:0] axis_streaming_data_rx_tkeep,
  input  logic                           axis_streaming_data_rx_tlast,
  output logic                           axis_streaming_data_rx_tready,
  output logic [CNT_W-1:0]               pkt_count,
  output logic [CNT_W-1:0]               data_err_count,
  output logic [CNT_W-1:0]               len_err_count,
  output logic [CNT_W-1:0]               user_err_count,
  output logic [CNT_W-1:0]               drop_count,
  output logic                           chk_locked
);

  localparam int NUM_LANES = G_AXIS_DATA_WIDTH / LANE_W;
  localparam int KEEP_W    = G_AXIS_DATA_WIDTH / 8;

  logic clk, rst, enable, clear;
  assign clk    = axis_streaming_data_clk;
  assign rst    = axis_streaming_arst;
  assign enable = axis_data_chk_enable;
  assign clear  = axis_data_chk_clear;

  logic tready_r, accept;
  assign axis_streaming_data_rx_tready = tready_r;
  assign accept = axis_streaming_data_rx_tvalid & tready_r;

  // Lane 0 carries the packet's sequence number and beat index.
  logic [SEQ_W-1:0]  in_seq;
  logic [BEAT_W-1:0] in_beat;
  assign in_seq  = axis_streaming_data_rx_tdata[63:32];
  assign in_beat = axis_streaming_data_rx_tdata[31:8];

  // ---------------------------------------------------------------- FSM
  chk_state_e        state, state_nx;
  logic [SEQ_W-1:0]  exp_seq, exp_seq_nx;   // seq of the current/last packet
  logic [15:0]       beat_idx, beat_idx_nx;
  logic              locked_nx;
  logic              last_idx, take;
  pkt_ctl_t          ctl;
  logic [SEQ_W-1:0]  cur_seq;
  logic [BEAT_W-1:0] cur_beat;

  assign last_idx = (beat_idx == (pkt_length - 16'd1));

  // Next-state, sequence tracking and per-beat control for accepted beats.
  always_comb begin
    state_nx    = state;
    exp_seq_nx  = exp_seq;
    beat_idx_nx = beat_idx;
    locked_nx   = chk_locked;
    ctl         = '0;
    cur_seq     = exp_seq;
    cur_beat    = {8'd0, beat_idx};
    take        = 1'b0;
    if (clear || !enable) begin
      state_nx    = ST_HUNT;
      beat_idx_nx = '0;
      locked_nx   = 1'b0;
    end else if (accept) begin
      unique case (state)
        ST_HUNT: begin
          // Only a beat-0 beat can start a packet; everything else is dropped.
          if (in_beat == '0) begin
            take       = 1'b1;
            locked_nx  = 1'b1;
            exp_seq_nx = in_seq;
            cur_seq    = in_seq;
            ctl.sop    = 1'b1;
          end
        end
        ST_CHECK: begin
          take = 1'b1;
          if (beat_idx == '0) begin
            // Resync to the received seq; the gap (zero when in order) is
            // the number of packets that never arrived.
            ctl.sop    = 1'b1;
            ctl.drop   = in_seq - exp_seq - 32'd1;
            exp_seq_nx = in_seq;
            cur_seq    = in_seq;
          end
        end
        ST_SKIP: begin
          if (axis_streaming_data_rx_tlast) begin
            ctl.close   = 1'b1;
            ctl.len_err = 1'b1;
            ctl.user    = axis_streaming_data_rx_tuser;
            state_nx    = ST_CHECK;
            beat_idx_nx = '0;
          end
        end
        default: state_nx = ST_HUNT;
      endcase
      if (take) begin
        ctl.cmp = 1'b1;
        if (axis_streaming_data_rx_tlast) begin
          ctl.close   = 1'b1;
          ctl.len_err = ~last_idx;
          ctl.user    = axis_streaming_data_rx_tuser;
          state_nx    = ST_CHECK;
          beat_idx_nx = '0;
        end else if (last_idx) begin
          // Overlong packet: the length error is implied by SKIP's close.
          state_nx    = ST_SKIP;
          beat_idx_nx = '0;
        end else begin
          state_nx    = ST_CHECK;
          beat_idx_nx = beat_idx + 16'd1;
        end
      end
    end
  end

  // FSM and sequence state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HUNT;
      exp_seq    <= '0;
      beat_idx   <= '0;
      chk_locked <= 1'b0;
    end else begin
      state      <= state_nx;
      exp_seq    <= exp_seq_nx;
      beat_idx   <= beat_idx_nx;
      chk_locked <= locked_nx;
    end
  end

  // ---------------------------------------------------------------- tready
`ifdef AXIS_DATA_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr, lfsr_nx;
  assign lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Pseudo-random backpressure: low when the three LSBs are zero (~1 in 8).
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= 16'hACE1;
      tready_r <= 1'b0;
    end else begin
      lfsr     <= lfsr_nx;
      tready_r <= ~enable | (lfsr_nx[2:0] != 3'd0);
    end
  end
`else
  // tready is low only while in reset.
  always_ff @(posedge clk) begin
    if (rst) tready_r <= 1'b0;
    else     tready_r <= 1'b1;
  end
`endif

  // ---------------------------------------------------------------- stage 1
  logic                  flush;
  pkt_ctl_t              s1_ctl, s2_ctl;
  logic [G_AXIS_DATA_WIDTH-1:0] s1_data;
  logic [KEEP_W-1:0]     s1_keep;
  logic [SEQ_W-1:0]      s1_seq;
  logic [BEAT_W-1:0]     s1_beat;

  assign flush = rst | clear | ~enable;

  // Stage-1 control; cleared on reset, clear or disable so nothing closes.
  always_ff @(posedge clk) begin
    if (flush) s1_ctl <= '0;
    else       s1_ctl <= ctl;
  end

  // Stage-1 datapath: accepted beat plus its expected seq/beat fields.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data <= axis_streaming_data_rx_tdata;
      s1_keep <= axis_streaming_data_rx_tkeep;
      s1_seq  <= cur_seq;
      s1_beat <= cur_beat;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [NUM_LANES-1:0] lane_mis;

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    axis_data_chk_lane_cmp #(.LANE_IDX(j)) u_lane (
      .clk      (clk),
      .data     (s1_data[j*LANE_W +: LANE_W]),
      .keep     (s1_keep[j*(LANE_W/8) +: (LANE_W/8)]),
      .exp_seq  (s1_seq),
      .exp_beat (s1_beat),
      .mismatch (lane_mis[j])
    );
  end

  // Stage-2 control, aligned with the registered lane compare results.
  always_ff @(posedge clk) begin
    if (flush) s2_ctl <= '0;
    else       s2_ctl <= s1_ctl;
  end

  // ---------------------------------------------------------------- counters
  logic err_acc, pkt_err;
  assign pkt_err = (s2_ctl.sop ? 1'b0 : err_acc) | (s2_ctl.cmp & (|lane_mis));

  // Accumulate the packet's data-error flag; one counter bump per close.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_acc        <= 1'b0;
      pkt_count      <= '0;
      data_err_count <= '0;
      len_err_count  <= '0;
      user_err_count <= '0;
      drop_count     <= '0;
    end else if (enable) begin
      if (s2_ctl.close) begin
        err_acc <= 1'b0;
        if (s2_ctl.len_err)   len_err_count  <= sat_add(len_err_count, 32'd1);
        else if (pkt_err)     data_err_count <= sat_add(data_err_count, 32'd1);
        else if (s2_ctl.user) user_err_count <= sat_add(user_err_count, 32'd1);
        else                  pkt_count      <= sat_add(pkt_count, 32'd1);
      end else if (s2_ctl.cmp) begin
        err_acc <= pkt_err;
      end
      if (s2_ctl.drop != '0) drop_count <= sat_add(drop_count, s2_ctl.drop);
    end
  end

endmodule

// File: tb/tb_axis_data_chk.sv
// Bench for axis_data_chk: directed scenarios plus a randomized packet stream,
// scored against a packet-level reference model of the checker's rules.
module tb_axis_data_chk;

  localparam int G  = 1024;
  localparam int NL = G / 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en, clr;
  logic [15:0]     plen;
  logic [G-1:0]    tdata;
  logic [G/8-1:0]  tkeep;
  logic            tvalid, tuser, tlast, tready;
  logic [31:0]     pkt_c, data_c, len_c, user_c, drop_c;
  logic            locked;

  axis_data_chk #(.G_AXIS_DATA_WIDTH(G)) dut (
    .axis_streaming_data_clk       (clk),
    .axis_streaming_arst           (rst),
    .axis_data_chk_enable          (en),
    .axis_data_chk_clear           (clr),
    .pkt_length                    (plen),
    .axis_streaming_data_rx_tdata  (tdata),
    .axis_streaming_data_rx_tvalid (tvalid),
    .axis_streaming_data_rx_tuser  (tuser),
    .axis_streaming_data_rx_tkeep  (tkeep),
    .axis_streaming_data_rx_tlast  (tlast),
    .axis_streaming_data_rx_tready (tready),
    .pkt_count                     (pkt_c),
    .data_err_count                (data_c),
    .len_err_count                 (len_c),
    .user_err_count                (user_c),
    .drop_count                    (drop_c),
    .chk_locked                    (locked)
  );

  int checks = 0, failures = 0;
  int tr_low = 0;
  bit mon_on = 0;

  // Reference model state (packet granularity).
  logic [31:0] e_pkt, e_data, e_len, e_user, e_drop, m_seq;
  bit          m_locked;
  int          m_len;

  always @(negedge clk) if (mon_on && en && !tready) tr_low++;

  function automatic logic [G-1:0] mk_beat(input logic [31:0] s, input int b);
    logic [G-1:0] v;
    for (int j = 0; j < NL; j++) v[j*64 +: 64] = {s, 24'(b), 8'(j)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pkt"},    pkt_c,  e_pkt);
    chk({tag, "_data"},   data_c, e_data);
    chk({tag, "_len"},    len_c,  e_len);
    chk({tag, "_user"},   user_c, e_user);
    chk({tag, "_drop"},   drop_c, e_drop);
    chk({tag, "_locked"}, {31'd0, locked}, {31'd0, m_locked});
  endtask

  task automatic model_zero();
    e_pkt = 0; e_data = 0; e_len = 0; e_user = 0; e_drop = 0;
    m_seq = 0; m_locked = 0;
  endtask

  // A packet seen from beat 'start' with nb total beats, as the checker rules
  // classify it: hunting needs a beat-0 start; gaps add to drops; one counter
  // per packet with priority length > data > user > good.
  task automatic model_pkt(input logic [31:0] s, input int nb, input int start,
                           input bit corrupt, input bit user);
    if (!m_locked) begin
      if (start != 0) return;
      m_locked = 1;
    end else if (s != m_seq + 32'd1) begin
      e_drop = e_drop + (s - m_seq - 32'd1);
    end
    m_seq = s;
    if (nb != m_len)  e_len++;
    else if (corrupt) e_data++;
    else if (user)    e_user++;
    else              e_pkt++;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    int n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = tready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      checks++; failures++;
      $error("FAIL handshake_timeout observed=tready_low expected=accept_within_200");
    end
  endtask

  task automatic drive_beats(input logic [31:0] s, input int from, input int to,
                             input bit last, input bit user, input int cb,
                             input int cbit, input bit ckeep, input bit gaps,
                             input bit clr_last);
    for (int b = from; b <= to; b++) begin
      if (gaps && $urandom_range(0, 4) == 0) begin
        tvalid = 0; tlast = 0;
        @(posedge clk); #1;
      end
      tdata = mk_beat(s, b);
      tkeep = '1;
      if (b == cb) begin
        if (ckeep) tkeep[cbit/8] = 1'b0;
        else       tdata[cbit]   = ~tdata[cbit];
      end
      tlast  = last && (b == to);
      tuser  = tlast ? user : 1'($urandom_range(0, 1));
      clr    = clr_last && tlast;
      tvalid = 1;
      wait_accept();
    end
    tvalid = 0; tlast = 0; tuser = 0; clr = 0;
  endtask

  task automatic send_pkt(input logic [31:0] s, input int nb, input bit user,
                          input int cb, input int cbit, input bit ckeep, input bit gaps);
    drive_beats(s, 0, nb - 1, 1, user, cb, cbit, ckeep, gaps, 0);
    model_pkt(s, nb, 0, (cb >= 0 && cb < nb), user);
  endtask

  task automatic drain();
    tvalid = 0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int l);
    plen = 16'(l); m_len = l;
  endtask

  initial begin
    logic [31:0] base, s, p0;
    int nb, cb, cbit, lane;
    bit ckeep, user;

    rst = 1; en = 0; clr = 0; tvalid = 0; tdata = '0; tkeep = '1;
    tuser = 0; tlast = 0;
    set_len(64);
    model_zero();

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_tready", {31'd0, tready}, 32'd0);
    check_all("rst");
    rst = 0; en = 1;
    @(posedge clk); #1;
`ifndef AXIS_DATA_CHK_BACKPRESSURE_EN
    chk("tready_after_rst", {31'd0, tready}, 32'd1);
`endif
    mon_on = 1;

    // Ten clean 64-beat packets from a random starting sequence number
    base = $urandom;
    for (int i = 0; i < 10; i++) send_pkt(base + 32'(i), 64, 0, -1, 0, 0, 0);
    drain();
    check_all("clean10");
    chk("clean10_pkt_abs", pkt_c, 32'd10);

    // Idle clear
    clr = 1; @(posedge clk); #1; clr = 0;
    model_zero();
    drain();
    check_all("clear");

    // Bit flip, truncation, overlong, sequence gap 7->11, tuser
    send_pkt(0, 64, 0, -1, 0, 0, 0);
    send_pkt(1, 64, 0, -1, 0, 0, 0);
    send_pkt(2, 64, 0, -1, 0, 0, 0);
    send_pkt(3, 64, 0, 5, 700, 0, 0);
    drain();
    chk("flip_data_abs", data_c, 32'd1);
    send_pkt(4, 40, 0, -1, 0, 0, 0);
    send_pkt(5, 64, 0, -1, 0, 0, 1);
    send_pkt(6, 70, 0, -1, 0, 0, 0);
    send_pkt(7, 64, 0, -1, 0, 0, 0);
    drain();
    chk("overlong_len_abs", len_c, 32'd2);
    send_pkt(11, 64, 1, -1, 0, 0, 0);
    send_pkt(12, 64, 0, -1, 0, 0, 1);
    drain();
    check_all("plan");
    chk("plan_drop_abs", drop_c, 32'd3);

    // Counter latency: visible exactly two edges after the tlast handshake
    set_len(1);
    p0 = pkt_c;
    drive_beats(13, 0, 0, 1, 0, -1, 0, 0, 0, 0);
    model_pkt(13, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("lat_edge1", pkt_c, p0);
    @(posedge clk); #1;
    chk("lat_edge2", pkt_c, p0 + 32'd1);

    // Back-to-back single-beat packets
    for (int i = 0; i < 20; i++) send_pkt(14 + i, 1, 0, -1, 0, 0, 0);
    drain();
    check_all("b2b1");

    // Clear coinciding with a tlast: that packet is lost, sequence re-hunts
    set_len(4);
    drive_beats(40, 0, 3, 1, 0, -1, 0, 0, 0, 1);
    model_zero();
    drain();
    check_all("clr_tlast");
    send_pkt(50, 4, 0, -1, 0, 0, 0);
    send_pkt(51, 4, 0, -1, 0, 0, 0);
    drain();
    check_all("after_clr");

    // Disabled: beats swallowed, counters hold, sequence re-hunts on enable
    en = 0;
    drive_beats(60, 0, 3, 1, 0, -1, 0, 0, 0, 0);
    m_locked = 0;
    drain();
    check_all("disabled");
    en = 1;
    send_pkt(70, 4, 0, -1, 0, 0, 0);
    send_pkt(71, 4, 0, -1, 0, 0, 0);
    drain();
    check_all("reenable");

    // Reset at beat 20, then the rest of that packet and fresh ones
    set_len(64);
    drive_beats(80, 0, 20, 0, 0, -1, 0, 0, 0, 0);
    mon_on = 0;
    rst = 1;
    repeat (2) @(posedge clk); #1;
    model_zero();
    rst = 0;
    @(posedge clk); #1;
    mon_on = 1;
    drive_beats(80, 21, 63, 1, 0, -1, 0, 0, 0, 0);
    model_pkt(80, 64, 21, 0, 0);
    for (int i = 1; i <= 3; i++) send_pkt(80 + i, 64, 0, -1, 0, 0, 0);
    drain();
    check_all("rst_mid");
    chk("rst_mid_pkt_abs", pkt_c, 32'd3);

    // Randomized stream in three blocks with different packet lengths
    s = 83;
    for (int blk = 0; blk < 3; blk++) begin
      set_len($urandom_range(1, 6));
      for (int i = 0; i < 25; i++) begin
        s  = s + (($urandom_range(0, 99) < 85) ? 32'd1 : 32'($urandom_range(2, 5)));
        nb = ($urandom_range(0, 99) < 80) ? m_len : $urandom_range(1, m_len + 3);
        user = ($urandom_range(0, 9) == 0);
        cb = -1; cbit = 0; ckeep = 0;
        if ($urandom_range(0, 99) < 15) begin
          cb    = $urandom_range(0, nb - 1);
          lane  = (cb == 0) ? $urandom_range(1, NL - 1) : $urandom_range(0, NL - 1);
          ckeep = 1'($urandom_range(0, 1));
          cbit  = ckeep ? lane*64 + 8*$urandom_range(0, 7) : lane*64 + $urandom_range(0, 63);
        end
        send_pkt(s, nb, user, cb, cbit, ckeep, 1);
      end
      drain();
      check_all($sformatf("rand%0d", blk));
    end

`ifdef AXIS_DATA_CHK_BACKPRESSURE_EN
    chk("tready_low_seen", {31'd0, (tr_low > 0)}, 32'd1);
`else
    chk("tready_low_none", 32'(tr_low), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
